// File: rtl/wb_sram_slave_b3.sv
// Wishbone B3 slave window backed by a synchronous 32-bit word RAM.
// Handles classic cycles, linear incrementing bursts, programmable wait
// states before the first ack, byte-lane writes and error on any access
// outside the window (including a burst that runs off the top word).
module wb_sram_slave_b3 #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_m2s,
  input  logic [2:0]  wb_cti,
  input  logic        wb_bte,
  output logic [31:0] wb_dat_s2m,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_rty
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WINDOW    = 32'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [AW:0] IDX_ONE   = (AW + 1)'(1);
  localparam logic [2:0]  CTI_INCR  = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;

  typedef enum logic [2:0] {IDLE, WAIT, ACK, BURST, ERR} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [AW:0] idx_reg, idx_next;   // one extra bit so a burst can reach DEPTH
  logic        we_reg, we_next;

  logic [31:0]   offset;
  logic          in_range;
  logic          wr_en;
  logic          wr_commit;
  logic          ack;
  logic          err;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  wire  [31:0]   rd_data;

  assign offset    = wb_adr - BASE_ADDR;
  assign in_range  = offset < WINDOW;
  assign wr_idx    = idx_reg[AW-1:0];
  // Read the word the next cycle will need, so data is ready in its ack cycle.
  assign rd_idx    = idx_next[AW-1:0];
  // A write that coincides with reset is dropped; memory keeps its contents.
  assign wr_commit = wr_en && !rst;

  // Next-state, index bookkeeping and bus responses.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    we_next    = we_reg;
    ack        = 1'b0;
    err        = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          if (!in_range) begin
            state_next = ERR;
          end else begin
            idx_next = {1'b0, offset[AW+1:2]};
            we_next  = wb_we;
            if (WAIT_STATES == 0) begin
              state_next = ACK;
            end else begin
              state_next = WAIT;
              cnt_next   = WAIT_LOAD;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = ACK;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ACK: begin
        ack   = 1'b1;
        wr_en = we_reg;
        if (wb_cti == CTI_INCR && !wb_bte && wb_we == we_reg) begin
          state_next = BURST;
          idx_next   = idx_reg + IDX_ONE;
        end else begin
          state_next = IDLE;
        end
      end
      BURST: begin
        // A low strobe stalls the burst with the index held.
        if (wb_cyc && wb_stb) begin
          if (idx_reg[AW]) begin
            err        = 1'b1;
            state_next = IDLE;
          end else begin
            ack   = 1'b1;
            wr_en = we_reg;
            if (wb_cti == CTI_INCR) idx_next   = idx_reg + IDX_ONE;
            else                    state_next = IDLE;
          end
        end
      end
      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Master abandoning the cycle wins over everything else.
    if (!wb_cyc) state_next = IDLE;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      we_reg    <= we_next;
    end
  end

  // One RAM per byte lane so each select bit gates its own write port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    // Lane write on commit, registered read of the prefetch index.
    always_ff @(posedge clk) begin
      if (wr_commit && wb_sel[gi]) lane_mem[wr_idx] <= wb_dat_m2s[8*gi +: 8];
      lane_rd_reg <= lane_mem[rd_idx];
    end

    assign rd_data[8*gi +: 8] = lane_rd_reg;
  end

  assign wb_ack     = ack;
  assign wb_err     = err;
  assign wb_rty     = 1'b0;
  assign wb_dat_s2m = ack ? rd_data : 32'h0;

endmodule

// File: tb/tb_wb_sram_slave_b3.sv
// Bench for wb_sram_slave_b3: three instances (0, 3 and 5 wait states)
// driven by directed steps and random transfers, checked against a word
// array model of each memory and the expected ack/err cycle schedule.
module tb_wb_sram_slave_b3;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;
  localparam int          WS2   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc, stb, we, bte;
  logic [31:0] adr  [3];
  logic [3:0]  sel  [3];
  logic [31:0] wdat [3];
  logic [2:0]  cti  [3];
  wire  [31:0] rdat [3];
  wire  [2:0]  ack, err, rty;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_rd;
  logic [31:0] mem_m [3][DEPTH];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wb_sram_slave_b3 #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .WAIT_STATES(gi == 0 ? WS0 : (gi == 1 ? WS1 : WS2))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr    (adr[gi]),
      .wb_cyc    (cyc[gi]),
      .wb_stb    (stb[gi]),
      .wb_we     (we[gi]),
      .wb_sel    (sel[gi]),
      .wb_dat_m2s(wdat[gi]),
      .wb_cti    (cti[gi]),
      .wb_bte    (bte[gi]),
      .wb_dat_s2m(rdat[gi]),
      .wb_ack    (ack[gi]),
      .wb_err    (err[gi]),
      .wb_rty    (rty[gi])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : ((d == 1) ? WS1 : WS2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nothing may be driven by the slave outside an ack/err beat.
  task automatic idle_chk(input int d, input string tag);
    chk({tag, "_ack"}, 32'(ack[d]), 32'd0);
    chk({tag, "_err"}, 32'(err[d]), 32'd0);
    chk({tag, "_dat"}, rdat[d], 32'd0);
    chk({tag, "_rty"}, 32'(rty[d]), 32'd0);
  endtask

  // One transfer: classic when nbeats==1, otherwise a linear burst whose
  // last beat carries cti=111. stall_at drops stb for one cycle before that
  // beat number. Expected: first response 1+WS cycles after the request
  // (1 cycle for an out-of-window err), then one beat per strobed cycle,
  // err instead of ack on any beat whose word index is DEPTH or more.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input int nbeats,
                      input int stall_at, input logic [31:0] dat0, input logic [3:0] sel0,
                      input bit rnd);
    logic [31:0] off, widx, cur;
    int          lat, beat;
    bit          done, stalled;
    off     = a - BASE;
    widx    = off >> 2;
    lat     = (off < 32'(DEPTH * 4)) ? 1 + ws_of(d) : 1;
    beat    = 0;
    done    = 1'b0;
    stalled = 1'b0;
    tick();
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = sel0;
    wdat[d] = dat0; bte[d] = 1'b0;
    cti[d] = (nbeats == 1) ? 3'b000 : 3'b010;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      idle_chk(d, "wait");
      tick();
    end
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (stb[d]) begin
        cur = widx + 32'(beat);
        if (cur >= 32'(DEPTH)) begin
          chk("beat_err", 32'(err[d]), 32'd1);
          chk("beat_noack", 32'(ack[d]), 32'd0);
          done = 1'b1;
        end else begin
          chk("beat_ack", 32'(ack[d]), 32'd1);
          chk("beat_noerr", 32'(err[d]), 32'd0);
          if (!w) begin
            chk("rdat", rdat[d], mem_m[d][int'(cur)]);
            last_rd = rdat[d];
          end else begin
            for (int b = 0; b < 4; b++)
              if (sel[d][b]) mem_m[d][int'(cur)][8*b +: 8] = wdat[d][8*b +: 8];
          end
          beat++;
          if (beat == nbeats) done = 1'b1;
        end
      end else begin
        idle_chk(d, "stall");
      end
      tick();
      if (done) begin
        cyc[d] = 1'b0; stb[d] = 1'b0; cti[d] = 3'b000;
      end else if (beat == stall_at && !stalled) begin
        stb[d] = 1'b0;
        stalled = 1'b1;
      end else begin
        stb[d]  = 1'b1;
        cti[d]  = (beat == nbeats - 1) ? 3'b111 : 3'b010;
        wdat[d] = $urandom;
        if (rnd) sel[d] = 4'($urandom);
      end
    end
    if (!done) begin
      chk("xfer_timeout", 32'd0, 32'd1);
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    @(negedge clk);
    idle_chk(d, "after");
  endtask

  // Write request abandoned while still in its wait states.
  task automatic abort_wr(input int d, input logic [31:0] a, input int hold);
    tick();
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; sel[d] = 4'hF;
    wdat[d] = $urandom; cti[d] = 3'b000;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      idle_chk(d, "abort_pre");
      tick();
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    for (int k = 0; k < ws_of(d) + 2; k++) begin
      @(negedge clk);
      idle_chk(d, "abort_post");
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          w, oor;
    int          d, nb, stall, word;
    logic [31:0] a;
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; bte = '0;
    for (int i = 0; i < 3; i++) begin
      adr[i] = '0; sel[i] = '0; wdat[i] = '0; cti[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) idle_chk(i, "reset");
    tick();
    rst = 1'b0;

    // Fill every word of every instance so the model is fully defined.
    for (int i = 0; i < 3; i++) xfer(i, 1'b1, BASE, DEPTH, -1, $urandom, 4'hF, 1'b0);

    // Classic write then read back, zero wait states.
    xfer(0, 1'b1, BASE + 32'h8, 1, -1, 32'hDEADBEEF, 4'hF, 1'b0);
    xfer(0, 1'b0, BASE + 32'h8, 1, -1, 32'h0, 4'hF, 1'b0);
    chk("deadbeef", last_rd, 32'hDEADBEEF);

    // Three wait states: ack four cycles after the request.
    xfer(1, 1'b0, BASE + 32'h4, 1, -1, 32'h0, 4'hF, 1'b0);

    // Partial byte-lane write.
    xfer(0, 1'b1, BASE + 32'h14, 1, -1, 32'hAABBCCDD, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 32'h14, 1, -1, 32'h11223344, 4'b0101, 1'b0);
    xfer(0, 1'b0, BASE + 32'h14, 1, -1, 32'h0, 4'hF, 1'b0);
    chk("sel_0101", last_rd, 32'hAA22CC44);

    // Write with no lanes selected leaves the word alone.
    xfer(0, 1'b1, BASE + 32'h18, 1, -1, 32'h0BADF00D, 4'h0, 1'b0);
    xfer(0, 1'b0, BASE + 32'h18, 1, -1, 32'h0, 4'hF, 1'b0);

    // Four-beat read burst over words holding 1..4.
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, BASE + 32'(4 * i), 1, -1, 32'(i + 1), 4'hF, 1'b0);
    xfer(0, 1'b0, BASE, 4, -1, 32'h0, 4'hF, 1'b0);
    chk("burst_last", last_rd, 32'd4);

    // Out-of-window accesses, above and below, then word 0 must be intact.
    xfer(0, 1'b0, BASE + 32'(DEPTH * 4), 1, -1, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 32'(DEPTH * 4) + 32'h1, 1, -1, 32'hFFFFFFFF, 4'hF, 1'b0);
    xfer(1, 1'b1, BASE - 32'h4, 1, -1, 32'hFFFFFFFF, 4'hF, 1'b0);
    xfer(0, 1'b0, BASE, 1, -1, 32'h0, 4'hF, 1'b0);
    chk("word0_intact", last_rd, 32'd1);

    // Bursts running off the top word.
    xfer(1, 1'b1, BASE + 32'(4 * (DEPTH - 2)), 4, -1, $urandom, 4'hF, 1'b0);
    xfer(1, 1'b0, BASE + 32'(4 * (DEPTH - 2)), 4, -1, 32'h0, 4'hF, 1'b0);
    xfer(1, 1'b0, BASE, 1, -1, 32'h0, 4'hF, 1'b0);

    // Strobe stalls inside bursts.
    xfer(2, 1'b0, BASE + 32'h8, 4, 2, 32'h0, 4'hF, 1'b0);
    xfer(2, 1'b1, BASE + 32'h8, 3, 1, $urandom, 4'hF, 1'b1);
    xfer(2, 1'b0, BASE + 32'h8, 3, -1, 32'h0, 4'hF, 1'b0);

    // Write abandoned during wait states, then confirm memory unchanged.
    abort_wr(2, BASE + 32'hC, 2);
    xfer(2, 1'b0, BASE + 32'hC, 1, -1, 32'h0, 4'hF, 1'b0);

    // Reset in the middle of a read burst.
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = BASE + 32'h10;
    sel[0] = 4'hF; cti[0] = 3'b010;
    @(negedge clk);
    idle_chk(0, "rstb_req");
    tick();
    @(negedge clk);
    chk("rstb_ack0", 32'(ack[0]), 32'd1);
    chk("rstb_dat0", rdat[0], mem_m[0][4]);
    tick();
    @(negedge clk);
    chk("rstb_ack1", 32'(ack[0]), 32'd1);
    chk("rstb_dat1", rdat[0], mem_m[0][5]);
    rst = 1'b1;
    tick();
    @(negedge clk);
    idle_chk(0, "rstb_hit");
    tick();
    rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; cti[0] = 3'b000;
    @(negedge clk);
    idle_chk(0, "rstb_rel");
    xfer(0, 1'b0, BASE + 32'h10, 2, -1, 32'h0, 4'hF, 1'b0);

    // Random transfers across all three instances.
    for (int r = 0; r < 36; r++) begin
      d     = int'($urandom_range(0, 2));
      w     = 1'($urandom);
      word  = int'($urandom_range(0, DEPTH - 1));
      nb    = int'($urandom_range(1, 4));
      stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
      oor   = ($urandom_range(0, 7) == 0);
      a     = BASE + 32'(4 * word) + 32'($urandom_range(0, 3));
      if (oor) a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
      xfer(d, w, a, nb, stall, $urandom, 4'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
